// File: rtl/fp16_pkg.sv
// fp16_pkg: shared FP16 constants, the argmax FSM state type and the NaN helper.
package fp16_pkg;

    localparam int unsigned FP16_W        = 16;
    localparam int unsigned FP16_SIGN_BIT = 15;
    localparam logic [4:0]  FP16_EXP_MAX  = 5'h1F;

    localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
    localparam logic [15:0] FP16_NEG_ZERO = 16'h8000;
    localparam logic [15:0] FP16_QNAN     = 16'h7E00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // NaN: all-ones exponent with a non-zero mantissa (Inf has a zero mantissa)
    function automatic logic is_nan(input logic [FP16_W-1:0] x);
        return (x[14:10] == FP16_EXP_MAX) && (x[9:0] != 10'd0);
    endfunction

endpackage

// File: rtl/fp16_gt.sv
// fp16_gt: combinational "candidate a beats incumbent b" test for FP16 values.
// A non-NaN always beats a NaN, a NaN never wins, otherwise strict FP16 ordering
// with +0 == -0, infinities ordered normally and subnormals ordered by raw bits.
module fp16_gt
    import fp16_pkg::*;
(
    input  logic [FP16_W-1:0] a,
    input  logic [FP16_W-1:0] b,
    output logic              a_gt_b
);

    logic        w_a_nan;
    logic        w_b_nan;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [14:0] w_a_mag;
    logic [14:0] w_b_mag;
    logic        w_both_zero;
    logic        w_ord_gt;

    // Sign/magnitude ordering, then fold in the NaN rules
    always_comb begin
        w_a_nan     = is_nan(a);
        w_b_nan     = is_nan(b);
        w_a_neg     = a[FP16_SIGN_BIT];
        w_b_neg     = b[FP16_SIGN_BIT];
        w_a_mag     = a[14:0];
        w_b_mag     = b[14:0];
        w_both_zero = (w_a_mag == 15'd0) && (w_b_mag == 15'd0);
        w_ord_gt    = 1'b0;

        if (w_both_zero) begin
            w_ord_gt = 1'b0;
        end else if (w_a_neg != w_b_neg) begin
            w_ord_gt = !w_a_neg;
        end else if (!w_a_neg) begin
            w_ord_gt = (w_a_mag > w_b_mag);
        end else begin
            w_ord_gt = (w_a_mag < w_b_mag);
        end

        a_gt_b = !w_a_nan && (w_b_nan || w_ord_gt);
    end

endmodule

// File: rtl/fp16_argmax.sv
// fp16_argmax: captures NUM_CLASSES FP16 logits on start, scans them one per
// clock and reports the index/value of the largest plus a sticky NaN flag.
module fp16_argmax
    import fp16_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = 16,
    parameter  int unsigned NUM_CLASSES = 10,
    localparam int unsigned IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] logits,
    output logic                              busy,
    output logic                              done,
    output logic [IDX_W-1:0]                  class_idx,
    output logic [DATA_WIDTH-1:0]             max_val,
    output logic                              nan_seen
);

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DATA_WIDTH-1:0] r_elems [NUM_CLASSES];
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_best_idx;
    logic [DATA_WIDTH-1:0] r_best_val;
    logic                  r_nan_acc;

    logic                  r_busy;
    logic                  r_done;
    logic [IDX_W-1:0]      r_class_idx;
    logic [DATA_WIDTH-1:0] r_max_val;
    logic                  r_nan_seen;

    logic [DATA_WIDTH-1:0] w_cand;
    logic                  w_repl;
    logic                  w_last;
    logic [IDX_W-1:0]      w_best_idx_nxt;
    logic [DATA_WIDTH-1:0] w_best_val_nxt;
    logic                  w_nan_nxt;

    // Candidate versus current best
    fp16_gt u_gt (
        .a      (w_cand),
        .b      (r_best_val),
        .a_gt_b (w_repl)
    );

    // Current element and the post-update best for this scan step
    always_comb begin
        w_cand         = r_elems[r_ptr];
        w_last         = (r_ptr == IDX_W'(NUM_CLASSES - 1));
        w_best_idx_nxt = w_repl ? r_ptr  : r_best_idx;
        w_best_val_nxt = w_repl ? w_cand : r_best_val;
        w_nan_nxt      = r_nan_acc | is_nan(w_cand);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: start is only honoured in IDLE, DONE lasts one cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = SCAN;
            SCAN:    if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Status outputs registered from the next state so they track r_state exactly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            r_done <= (w_state_nxt == DONE);
        end
    end

    // Capture on start, running best during SCAN, result load on the last element
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
                r_elems[i] <= '0;
            end
            r_ptr       <= '0;
            r_best_idx  <= '0;
            r_best_val  <= FP16_POS_ZERO;
            r_nan_acc   <= 1'b0;
            r_class_idx <= '0;
            r_max_val   <= FP16_POS_ZERO;
            r_nan_seen  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
                            r_elems[i] <= logits[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        r_best_idx <= '0;
                        r_best_val <= logits[DATA_WIDTH-1:0];
                        r_nan_acc  <= is_nan(logits[DATA_WIDTH-1:0]);
                        r_ptr      <= IDX_W'(1);
                    end
                end
                SCAN: begin
                    r_best_idx <= w_best_idx_nxt;
                    r_best_val <= w_best_val_nxt;
                    r_nan_acc  <= w_nan_nxt;
                    if (w_last) begin
                        r_class_idx <= w_best_idx_nxt;
                        r_max_val   <= w_best_val_nxt;
                        r_nan_seen  <= w_nan_nxt;
                    end else begin
                        r_ptr <= r_ptr + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign class_idx = r_class_idx;
    assign max_val   = r_max_val;
    assign nan_seen  = r_nan_seen;

endmodule

// File: tb/tb_fp16_argmax.sv
// tb_fp16_argmax: table vectors, hand-built multi-cycle sequences and random
// buses checked against a real-valued argmax reference model.
module tb_fp16_argmax;

    localparam int unsigned N  = 10;
    localparam int unsigned W  = 16;
    localparam int unsigned BW = N * W;

    typedef struct {
        logic [BW-1:0] bus;
        logic [3:0]    idx;
        logic [15:0]   val;
        logic          nan;
    } vec_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [BW-1:0] logits;
    logic          busy;
    logic          done;
    logic [3:0]    class_idx;
    logic [15:0]   max_val;
    logic          nan_seen;

    int n_cmp;
    int n_err;

    fp16_argmax #(.DATA_WIDTH(16), .NUM_CLASSES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .logits    (logits),
        .busy      (busy),
        .done      (done),
        .class_idx (class_idx),
        .max_val   (max_val),
        .nan_seen  (nan_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- bus helpers ----------------
    function automatic logic [BW-1:0] fill(input logic [15:0] v);
        logic [BW-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = v;
        return r;
    endfunction

    function automatic logic [BW-1:0] setel(input logic [BW-1:0] b, input int i, input logic [15:0] v);
        logic [BW-1:0] r;
        r = b;
        r[i*W +: W] = v;
        return r;
    endfunction

    function automatic logic [BW-1:0] rand_bus();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- reference model (real-valued) ----------------
    function automatic real pow2(input int n);
        real r;
        r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic logic m_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction

    function automatic real fval(input logic [15:0] x);
        int  e;
        int  m;
        real mag;
        e = int'(x[14:10]);
        m = int'(x[9:0]);
        if (e == 31)     mag = 1.0e30;
        else if (e == 0) mag = real'(m) * pow2(-24);
        else             mag = real'(1024 + m) * pow2(e - 25);
        return x[15] ? -mag : mag;
    endfunction

    task automatic ref_argmax(input logic [BW-1:0] b, output logic [3:0] idx,
                              output logic [15:0] val, output logic nan);
        int          bi;
        logic [15:0] bv;
        logic [15:0] c;
        bi  = 0;
        bv  = b[15:0];
        nan = m_nan(bv);
        for (int i = 1; i < N; i++) begin
            c   = b[i*W +: W];
            nan = nan | m_nan(c);
            if (m_nan(bv) && !m_nan(c)) begin
                bi = i; bv = c;
            end else if (!m_nan(bv) && !m_nan(c) && (fval(c) > fval(bv))) begin
                bi = i; bv = c;
            end
        end
        idx = 4'(bi);
        val = bv;
    endtask

    // ---------------- one full classification ----------------
    // Optional second start pulse (with a different bus) at negedge pulse_at.
    task automatic run_vec(input string tag, input logic [BW-1:0] bus,
                           input logic [3:0] e_idx, input logic [15:0] e_val, input logic e_nan,
                           input int pulse_at, input logic [BW-1:0] bus2);
        int done_at;
        int busy_cnt;
        done_at  = 0;
        busy_cnt = 0;
        @(negedge clk);
        start  = 1'b1;
        logits = bus;
        @(posedge clk);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start  = 1'b0;
                logits = rand_bus();
            end
            if (i == pulse_at) begin
                start  = 1'b1;
                logits = bus2;
            end
            if (i == pulse_at + 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_at = i;
                break;
            end
        end
        start = 1'b0;
        chk({tag, " latency"}, 32'(done_at), 32'd10);
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd10);
        chk({tag, " class_idx"}, 32'(class_idx), 32'(e_idx));
        chk({tag, " max_val"}, 32'(max_val), 32'(e_val));
        chk({tag, " nan_seen"}, 32'(nan_seen), 32'(e_nan));
        @(negedge clk);
        chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, " idle_after"}, 32'(busy), 32'd0);
        chk({tag, " hold_val"}, 32'(max_val), 32'(e_val));
    endtask

    vec_t          tbl [7];
    logic [BW-1:0] bus_a;
    logic [BW-1:0] bus_b;
    logic [BW-1:0] rb;
    logic [3:0]    r_idx;
    logic [15:0]   r_val;
    logic          r_nan;
    int            d_times [2];
    int            d_cnt;
    int            k;
    logic [15:0]   e;

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b1;
        start  = 1'b0;
        logits = '0;

        // Stimulus table
        tbl[0] = '{setel(fill(16'h3C00), 7, 16'h4000), 4'd7, 16'h4000, 1'b0};
        tbl[1] = '{setel(setel(fill(16'h3800), 2, 16'h4000), 5, 16'h4000), 4'd2, 16'h4000, 1'b0};
        tbl[2] = '{setel(fill(16'hBC00), 9, 16'hB800), 4'd9, 16'hB800, 1'b0};
        tbl[3] = '{setel(setel(fill(16'hBC00), 0, 16'h8000), 1, 16'h0000), 4'd0, 16'h8000, 1'b0};
        tbl[4] = '{setel(setel(fill(16'h3C00), 0, 16'h7E00), 3, 16'h7C00), 4'd3, 16'h7C00, 1'b1};
        tbl[5] = '{fill(16'h7E00), 4'd0, 16'h7E00, 1'b1};
        tbl[6] = '{setel(setel(fill(16'h8001), 4, 16'h0001), 6, 16'h03FF), 4'd6, 16'h03FF, 1'b0};

        // Reset state
        #3;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst class_idx", 32'(class_idx), 32'd0);
        chk("rst max_val", 32'(max_val), 32'd0);
        chk("rst nan_seen", 32'(nan_seen), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("tbl%0d", i), tbl[i].bus, tbl[i].idx, tbl[i].val, tbl[i].nan, 0, '0);
        end

        // Start pulse 3 cycles into a scan is ignored
        bus_a = tbl[0].bus;
        bus_b = setel(fill(16'h3C00), 1, 16'h7BFF);
        run_vec("ignore_start", bus_a, 4'd7, 16'h4000, 1'b0, 3, bus_b);

        // Start held high: back-to-back results 11 cycles apart, second uses new bus
        d_cnt = 0;
        d_times[0] = 0;
        d_times[1] = 0;
        @(negedge clk);
        start  = 1'b1;
        logits = bus_a;
        @(posedge clk);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) logits = bus_b;
            if (i == 12) start = 1'b0;
            if (done) begin
                d_times[d_cnt] = i;
                if (d_cnt == 0) begin
                    chk("b2b first idx", 32'(class_idx), 32'd7);
                    chk("b2b first val", 32'(max_val), 32'h4000);
                end else begin
                    chk("b2b second idx", 32'(class_idx), 32'd1);
                    chk("b2b second val", 32'(max_val), 32'h7BFF);
                end
                d_cnt++;
                if (d_cnt == 2) break;
            end
        end
        start = 1'b0;
        chk("b2b first latency", 32'(d_times[0]), 32'd10);
        chk("b2b second latency", 32'(d_times[1]), 32'd21);
        repeat (12) @(negedge clk);

        // Reset 5 cycles into a scan aborts immediately
        @(negedge clk);
        start  = 1'b1;
        logits = tbl[2].bus;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort class_idx", 32'(class_idx), 32'd0);
        chk("abort max_val", 32'(max_val), 32'd0);
        chk("abort nan_seen", 32'(nan_seen), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 2) reset = 1'b0;
            if (done) chk("abort no_done", 32'(done), 32'd0);
        end
        run_vec("after_abort", tbl[2].bus, 4'd9, 16'hB800, 1'b0, 0, '0);

        // Random buses with specials and duplicates against the reference model
        for (int t = 0; t < 30; t++) begin
            rb = '0;
            for (int i = 0; i < N; i++) begin
                k = int'($urandom_range(0, 7));
                case (k)
                    0: e = {1'($urandom_range(0, 1)), 5'h1F, 10'($urandom_range(1, 1023))};
                    1: e = {1'($urandom_range(0, 1)), 5'h1F, 10'h000};
                    2: e = {1'($urandom_range(0, 1)), 15'h0000};
                    3: e = (i > 0) ? rb[int'($urandom_range(0, i - 1))*W +: W] : 16'($urandom);
                    default: e = 16'($urandom);
                endcase
                rb[i*W +: W] = e;
            end
            ref_argmax(rb, r_idx, r_val, r_nan);
            run_vec($sformatf("rand%0d", t), rb, r_idx, r_val, r_nan, 0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp16_argmax.md
Name: fp16_argmax

Overview:
Classification stage directly downstream of the FC output layer (84 -> 10, FP16).
- Takes the packed bus of NUM_CLASSES FP16 logits on a start pulse.
- Scans the logits sequentially, one element per clock, and returns the index and value of the largest logit.
- Raises a one-cycle done pulse when the result is ready.
- Lets the bench and top level read a single class ID instead of dumping all 10 outputs.

Parameters:
DATA_WIDTH, 16, element width; only 16 (IEEE-754 binary16) is supported.
NUM_CLASSES, 10, number of logits on the input bus; minimum 2.
IDX_W, $clog2(NUM_CLASSES), width of the class index (localparam, derived).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
logits  input  NUM_CLASSES*DATA_WIDTH  packed logits; element i at [i*DATA_WIDTH +: DATA_WIDTH]
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; result valid this cycle
class_idx  output  IDX_W  index of maximum logit
max_val  output  DATA_WIDTH  FP16 value of maximum logit
nan_seen  output  1  at least one input element was NaN

Behaviour:
Reset (async, active-high):
- state = IDLE.
- busy, done, class_idx, max_val and nan_seen all 0.
- Scan registers cleared.

FSM states: IDLE, SCAN, DONE.

IDLE:
- start=1 at an edge captures the whole logits bus into an internal register.
- Best is initialised to element 0: best_idx=0, best_val=elem0, nan_acc=isnan(elem0).
- ptr is set to 1 and the FSM moves to SCAN.
- After capture, the logits input may change freely.

SCAN:
- Each edge compares elem[ptr] against best and updates best when it wins; nan_acc |= isnan(elem[ptr]).
- If ptr == NUM_CLASSES-1:
  - class_idx/max_val/nan_seen are loaded from the post-update best in the same edge.
  - The FSM moves to DONE.
- Otherwise ptr increments.

DONE:
- done=1 for exactly one cycle, then IDLE.
- class_idx, max_val and nan_seen hold until the next DONE or reset.

Latency: start sampled at edge k gives done=1 in the cycle following edge k+NUM_CLASSES-1, observed at edge k+NUM_CLASSES (10 cycles by default). Throughput is one classification per NUM_CLASSES+1 cycles.

start while busy (SCAN or DONE) is ignored, never queued. start sampled in IDLE on the cycle right after DONE is accepted.

Compare rule (candidate c replaces best b):
- NaN = exp 5'h1F with mantissa != 0.
- If b is NaN and c is not NaN: replace.
- If c is NaN: never replace.
- Otherwise replace only if c > b strictly, by FP16 ordering:
  - Signs differ: the positive operand is greater.
  - Both positive: larger magnitude [14:0] is greater.
  - Both negative: smaller magnitude is greater.
- +0 (0000) and -0 (8000) compare equal, so no replace.
- Ties keep the lowest index.
- ±Inf is ordered normally. Subnormals are ordered by raw magnitude with no flush.
- If all elements are NaN: class_idx=0, max_val=elem0, nan_seen=1.

Reset asserted mid-SCAN or in DONE aborts immediately:
- No done pulse.
- Outputs return to 0.

Decomposition:
- Package fp16_pkg holds:
  - FP16_EXP_MAX (5'h1F)
  - FP16_SIGN_BIT (15)
  - constants FP16_POS_ZERO / FP16_NEG_ZERO / FP16_QNAN (7E00)
  - state enum typedef {IDLE, SCAN, DONE}
  - function is_nan(fp16)
- One combinational sub-module, fp16_gt (inputs a, b; output a_gt_b, implementing the ordering above), so later stages (max-pool) can reuse it.

Test Plan:
- All 3C00 except idx7=4000 -> class_idx=7, max_val=4000, nan_seen=0; done observed exactly 10 edges after start; busy high for 10 cycles.
- idx2=4000, idx5=4000, rest 3800 -> class_idx=2 (tie keeps lowest), max_val=4000.
- All BC00 except idx9=B800 -> class_idx=9, max_val=B800. Then idx0=8000, idx1=0000, rest BC00 -> class_idx=0, max_val=8000 (±0 equal).
- idx0=7E00, idx3=7C00, rest 3C00 -> class_idx=3, max_val=7C00, nan_seen=1. Then all 7E00 -> class_idx=0, max_val=7E00, nan_seen=1.
- Pulse start again 3 cycles into a scan with different logits -> ignored, result matches first bus; start held continuously -> back-to-back results every 11 cycles.
- Assert reset 5 cycles into a scan -> busy=0 and all outputs 0 immediately, no done; a fresh start then completes normally with the correct result.
